// File: rtl/uart_fifo_bridge_if.sv
// Signal bundle between the serial byte side, the CPU load/store port and the bridge.
// Latency: none, this is wiring only.
// Backpressure: carried by tx_busy (serial side) and tx_full/rd_valid (CPU side).
interface uart_fifo_bridge_if #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
);
  localparam int RXCW = $clog2(RX_DEPTH) + 1;
  localparam int TXCW = $clog2(TX_DEPTH) + 1;

  // serial receiver / transmitter side
  logic [7:0]      rx_data;
  logic            new_rx_data;
  logic [7:0]      tx_data;
  logic            new_tx_data;
  logic            tx_busy;
  // CPU side
  logic [7:0]      rd_data;
  logic            rd_valid;
  logic            rd_en;
  logic [7:0]      wr_data;
  logic            wr_en;
  logic            tx_full;
  logic            rx_afull;
  logic [RXCW-1:0] rx_count;
  logic [TXCW-1:0] tx_count;
  logic            rx_ovf;
  logic            tx_ovf;
  logic            clr_ovf;

  // bridge view
  modport slave (
    input  rx_data, new_rx_data, tx_busy, rd_en, wr_data, wr_en, clr_ovf,
    output tx_data, new_tx_data, rd_data, rd_valid, tx_full, rx_afull,
           rx_count, tx_count, rx_ovf, tx_ovf
  );

  // environment view (serial core plus CPU)
  modport master (
    output rx_data, new_rx_data, tx_busy, rd_en, wr_data, wr_en, clr_ovf,
    input  tx_data, new_tx_data, rd_data, rd_valid, tx_full, rx_afull,
           rx_count, tx_count, rx_ovf, tx_ovf
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// RX/TX byte FIFOs between the serial byte interface and a CPU port, plus a TX drain FSM.
// Latency: RX byte visible one cycle after its strobe; TX byte strobed out no earlier than one cycle after the write.
// Backpressure: full FIFOs drop and set sticky overflow; TX drain waits while tx_busy is high, min 2 cycles between strobes.
module uart_fifo_bridge #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int RX_AFULL = 12
) (
  input logic             clk,
  input logic             rst_n,
  uart_fifo_bridge_if.slave bus
);
  localparam int RXAW = $clog2(RX_DEPTH);
  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int RXCW = RXAW + 1;
  localparam int TXCW = TXAW + 1;

  typedef enum logic {
    S_IDLE,
    S_GUARD
  } tx_state_t;

  // ---------------- RX FIFO ----------------
  logic [7:0]      rx_mem [RX_DEPTH];
  logic [RXAW-1:0] rx_wptr;
  logic [RXAW-1:0] rx_rptr;
  logic [RXCW-1:0] rx_cnt;
  logic            rx_ovf_q;
  logic            rx_full;
  logic            rx_push;
  logic            rx_pop;
  logic            rx_drop;

  assign rx_full = (rx_cnt == RXCW'(RX_DEPTH));
  assign rx_pop  = bus.rd_en && (rx_cnt != '0);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the byte
  assign rx_push = bus.new_rx_data && (!rx_full || rx_pop);
  assign rx_drop = bus.new_rx_data && !rx_push;

  // RX storage; no reset needed, contents are only observed while rd_valid is high
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= bus.rx_data;
  end

  // RX pointers, occupancy and sticky overflow; a drop beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_cnt   <= '0;
      rx_ovf_q <= 1'b0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
      if (rx_drop)          rx_ovf_q <= 1'b1;
      else if (bus.clr_ovf) rx_ovf_q <= 1'b0;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]      tx_mem [TX_DEPTH];
  logic [TXAW-1:0] tx_wptr;
  logic [TXAW-1:0] tx_rptr;
  logic [TXCW-1:0] tx_cnt;
  logic            tx_ovf_q;
  logic            tx_full_w;
  logic            tx_push;
  logic            tx_pop;
  logic            tx_drop;
  tx_state_t       tx_state;
  logic            tx_stb_q;
  logic [7:0]      tx_dat_q;

  assign tx_full_w = (tx_cnt == TXCW'(TX_DEPTH));
  // the drain FSM pops exactly when it launches a strobe
  assign tx_pop    = (tx_state == S_IDLE) && (tx_cnt != '0) && !bus.tx_busy;
  assign tx_push   = bus.wr_en && (!tx_full_w || tx_pop);
  assign tx_drop   = bus.wr_en && !tx_push;

  // TX storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= bus.wr_data;
  end

  // TX pointers, occupancy and sticky overflow; a drop beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_cnt   <= '0;
      tx_ovf_q <= 1'b0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
      if (tx_drop)          tx_ovf_q <= 1'b1;
      else if (bus.clr_ovf) tx_ovf_q <= 1'b0;
    end
  end

  // Drain FSM: one-cycle strobe from IDLE, then a GUARD cycle so the transmitter's busy can rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_stb_q <= 1'b0;
      tx_dat_q <= 8'h00;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_stb_q <= 1'b1;
            tx_dat_q <= tx_mem[tx_rptr];
            tx_state <= S_GUARD;
          end else begin
            tx_stb_q <= 1'b0;
          end
        end
        S_GUARD: begin
          tx_stb_q <= 1'b0;
          tx_state <= S_IDLE;
        end
        default: begin
          tx_stb_q <= 1'b0;
          tx_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign bus.rd_data     = rx_mem[rx_rptr];
  assign bus.rd_valid    = (rx_cnt != '0);
  assign bus.rx_count    = rx_cnt;
  assign bus.rx_afull    = (rx_cnt >= RXCW'(RX_AFULL));
  assign bus.rx_ovf      = rx_ovf_q;
  assign bus.tx_count    = tx_cnt;
  assign bus.tx_full     = tx_full_w;
  assign bus.tx_ovf      = tx_ovf_q;
  assign bus.tx_data     = tx_dat_q;
  assign bus.new_tx_data = tx_stb_q;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
// Strobes from the drain FSM are logged with their cycle number for order/spacing checks.
module tb_uart_fifo_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic [7:0] s_dat [$];
  int         s_cyc [$];

  always #5 clk = ~clk;

  uart_fifo_bridge_if #(.RX_DEPTH(16), .TX_DEPTH(16)) bus ();

  uart_fifo_bridge #(.RX_DEPTH(16), .TX_DEPTH(16), .RX_AFULL(12)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.new_tx_data === 1'b1) begin
      s_dat.push_back(bus.tx_data);
      s_cyc.push_back(cyc);
    end
  endtask

  function automatic logic [31:0] sent(input int i);
    return (i < s_dat.size()) ? {24'h0, s_dat[i]} : 32'hDEAD;
  endfunction

  initial begin
    logic [7:0] exp_b;
    bus.rx_data = 8'h00; bus.new_rx_data = 1'b0; bus.tx_busy = 1'b0;
    bus.rd_en = 1'b0; bus.wr_data = 8'h00; bus.wr_en = 1'b0; bus.clr_ovf = 1'b0;

    // ---- reset state ----
    tick(); tick();
    chk("rst_rx_count", bus.rx_count, 0);
    chk("rst_tx_count", bus.tx_count, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_tx_full", bus.tx_full, 0);
    chk("rst_rx_afull", bus.rx_afull, 0);
    chk("rst_new_tx", bus.new_tx_data, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_ovf", {bus.rx_ovf, bus.tx_ovf}, 2'b00);
    rst_n = 1'b1;
    tick();

    // ---- RX basic push/pop ----
    bus.new_rx_data = 1'b1;
    bus.rx_data = 8'h41; tick();
    chk("rx1_first_visible", bus.rd_data, 8'h41);
    bus.rx_data = 8'h42; tick();
    bus.rx_data = 8'h43; tick();
    bus.new_rx_data = 1'b0;
    chk("rx1_count3", bus.rx_count, 3);
    chk("rx1_head", bus.rd_data, 8'h41);
    bus.rd_en = 1'b1;
    tick(); chk("rx1_pop1", bus.rd_data, 8'h42); chk("rx1_cnt2", bus.rx_count, 2);
    tick(); chk("rx1_pop2", bus.rd_data, 8'h43);
    tick(); chk("rx1_empty", bus.rd_valid, 0);
    tick(); chk("rx1_underflow_cnt", bus.rx_count, 0); chk("rx1_no_ovf", bus.rx_ovf, 0);
    bus.rd_en = 1'b0;

    // ---- RX fill to overflow ----
    bus.new_rx_data = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.rx_data = 8'h80 + 8'(i);
      tick();
      if (i == 10) chk("rx2_afull_11", bus.rx_afull, 0);
      if (i == 11) chk("rx2_afull_12", bus.rx_afull, 1);
    end
    bus.new_rx_data = 1'b0;
    chk("rx2_count16", bus.rx_count, 16);
    chk("rx2_ovf", bus.rx_ovf, 1);
    chk("rx2_head", bus.rd_data, 8'h80);
    bus.clr_ovf = 1'b1; tick(); bus.clr_ovf = 1'b0;
    chk("rx2_clr", bus.rx_ovf, 0);
    bus.new_rx_data = 1'b1; bus.rx_data = 8'hAA; bus.rd_en = 1'b1;
    tick();
    bus.new_rx_data = 1'b0; bus.rd_en = 1'b0;
    chk("rx2_fullpp_cnt", bus.rx_count, 16);
    chk("rx2_fullpp_ovf", bus.rx_ovf, 0);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? (8'h81 + 8'(i)) : 8'hAA;
      chk("rx2_drain", bus.rd_data, exp_b);
      bus.rd_en = 1'b1; tick();
    end
    bus.rd_en = 1'b0;
    chk("rx2_drained", bus.rd_valid, 0);

    // ---- TX drain, transmitter idle ----
    s_dat.delete(); s_cyc.delete();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h10; tick();
    bus.wr_data = 8'h20; tick();
    bus.wr_data = 8'h30; tick();
    bus.wr_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("tx3_nstrobe", s_dat.size(), 3);
    chk("tx3_b0", sent(0), 8'h10);
    chk("tx3_b1", sent(1), 8'h20);
    chk("tx3_b2", sent(2), 8'h30);
    if (s_cyc.size() == 3) begin
      chk("tx3_gap01", s_cyc[1] - s_cyc[0], 2);
      chk("tx3_gap12", s_cyc[2] - s_cyc[1], 2);
    end
    chk("tx3_count0", bus.tx_count, 0);
    chk("tx3_hold", bus.tx_data, 8'h30);

    // ---- TX held off by tx_busy ----
    s_dat.delete(); s_cyc.delete();
    bus.tx_busy = 1'b1;
    bus.wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_data = 8'h51 + 8'(i); tick();
    end
    bus.wr_en = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("tx4_no_strobe", s_dat.size(), 0);
    chk("tx4_count4", bus.tx_count, 4);
    bus.tx_busy = 1'b0;
    tick();
    chk("tx4_first_stb", bus.new_tx_data, 1);
    chk("tx4_first_dat", bus.tx_data, 8'h51);
    for (int i = 0; i < 10; i++) tick();
    chk("tx4_nstrobe", s_dat.size(), 4);
    chk("tx4_b1", sent(1), 8'h52);
    chk("tx4_b3", sent(3), 8'h54);

    // ---- TX overflow and clear priority ----
    bus.new_rx_data = 1'b1; bus.rx_data = 8'h01; tick(); bus.new_rx_data = 1'b0;
    bus.tx_busy = 1'b1;
    bus.wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.wr_data = 8'h60 + 8'(i); tick();
    end
    chk("tx5_full", bus.tx_full, 1);
    chk("tx5_count16", bus.tx_count, 16);
    chk("tx5_ovf", bus.tx_ovf, 1);
    bus.clr_ovf = 1'b1; bus.wr_data = 8'hEE; tick();
    chk("tx5_clr_vs_drop", bus.tx_ovf, 1);
    bus.wr_en = 1'b0; tick();
    bus.clr_ovf = 1'b0;
    chk("tx5_clr", bus.tx_ovf, 0);
    s_dat.delete(); s_cyc.delete();
    bus.tx_busy = 1'b0; bus.wr_en = 1'b1; bus.wr_data = 8'h7F;
    tick();
    bus.wr_en = 1'b0; bus.tx_busy = 1'b1;
    chk("tx5_fullpp_stb", bus.new_tx_data, 1);
    chk("tx5_fullpp_dat", bus.tx_data, 8'h60);
    chk("tx5_fullpp_cnt", bus.tx_count, 16);
    chk("tx5_fullpp_ovf", bus.tx_ovf, 0);

    // ---- reset mid-drain ----
    #1 rst_n = 1'b0;
    #1;
    chk("rst6_stb", bus.new_tx_data, 0);
    chk("rst6_tx_count", bus.tx_count, 0);
    chk("rst6_rx_count", bus.rx_count, 0);
    chk("rst6_tx_data", bus.tx_data, 8'h00);
    chk("rst6_flags", {bus.tx_full, bus.rd_valid}, 2'b00);
    tick();
    rst_n = 1'b1; bus.tx_busy = 1'b0;
    s_dat.delete(); s_cyc.delete();
    for (int i = 0; i < 10; i++) tick();
    chk("rst6_no_strobe", s_dat.size(), 0);
    bus.wr_en = 1'b1; bus.wr_data = 8'h99; tick(); bus.wr_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rst6_new_n", s_dat.size(), 1);
    chk("rst6_new_b", sent(0), 8'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
